// File: rtl/frame_crc_tx.sv
// Block framer: buffers payload bytes, then streams them one per clock followed by
// a CRC-8 byte. start flags the first payload byte, stop flags the CRC byte, and a
// fixed idle gap follows every frame before the next one may start.
module frame_crc_tx #(
  parameter int unsigned  MAX_LEN    = 16,
  parameter int unsigned  GAP_CYCLES = 5,
  parameter logic [7:0]   CRC_POLY   = 8'h07,
  parameter logic [7:0]   CRC_INIT   = 8'h00,
  localparam int unsigned CntW       = $clog2(MAX_LEN + 1)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [7:0]      wr_data,
  input  logic            send,
  output logic            start,
  output logic            stop,
  output logic [7:0]      datain,
  output logic            busy,
  output logic [CntW-1:0] count,
  output logic            full,
  output logic            wr_drop
);

  localparam int unsigned IdxW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CntW-1:0] MaxCnt  = CntW'(MAX_LEN);
  // Gap counter is loaded with GAP_CYCLES-1 so the GAP state lasts GAP_CYCLES cycles.
  localparam logic [GapW-1:0] GapLast = (GAP_CYCLES > 0) ? GapW'(GAP_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    StIdle,
    StSendData,
    StSendCrc,
    StGap
  } state_e;

  // One byte of CRC-8, MSB first, no reflection.
  function automatic logic [7:0] crc_byte(input logic [7:0] crc_in, input logic [7:0] data);
    logic [7:0] c;
    c = crc_in ^ data;
    for (int i = 0; i < 8; i++) begin
      c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [CntW-1:0] count_q, count_d;
  logic [CntW-1:0] idx_q, idx_d;
  logic [GapW-1:0] gap_q, gap_d;
  logic [7:0]      crc_q, crc_d;
  logic            start_q, start_d;
  logic            stop_q, stop_d;
  logic [7:0]      datain_q, datain_d;
  logic            busy_q, busy_d;
  logic            full_q, full_d;
  logic            wr_drop_q, wr_drop_d;
  logic [7:0]      buf_q [MAX_LEN];
  logic [7:0]      buf_d [MAX_LEN];
  logic [7:0]      launch_byte;
  logic [7:0]      next_byte;

  // Next-state, buffer write and registered-output values.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    idx_d       = idx_q;
    gap_d       = gap_q;
    crc_d       = crc_q;
    start_d     = 1'b0;
    stop_d      = 1'b0;
    datain_d    = 8'h00;
    busy_d      = 1'b0;
    wr_drop_d   = 1'b0;
    buf_d       = buf_q;
    // With an empty buffer, the byte written alongside send is the first byte.
    launch_byte = (count_q == '0) ? wr_data : buf_q[0];
    next_byte   = buf_q[IdxW'(idx_q)];

    unique case (state_q)
      StIdle: begin
        if (wr_en) begin
          if (full_q) begin
            wr_drop_d = 1'b1;
          end else begin
            buf_d[IdxW'(count_q)] = wr_data;
            count_d               = count_q + 1'b1;
          end
        end
        // count_d already includes a write accepted this cycle.
        if (send && (count_d != '0)) begin
          state_d  = StSendData;
          start_d  = 1'b1;
          busy_d   = 1'b1;
          datain_d = launch_byte;
          crc_d    = crc_byte(CRC_INIT, launch_byte);
          idx_d    = CntW'(1);
        end
      end

      StSendData: begin
        busy_d    = 1'b1;
        wr_drop_d = wr_en;
        if (idx_q < count_q) begin
          datain_d = next_byte;
          crc_d    = crc_byte(crc_q, next_byte);
          idx_d    = idx_q + 1'b1;
        end else begin
          state_d  = StSendCrc;
          stop_d   = 1'b1;
          datain_d = crc_q;
        end
      end

      StSendCrc: begin
        wr_drop_d = wr_en;
        count_d   = '0;
        idx_d     = '0;
        crc_d     = CRC_INIT;
        if (GAP_CYCLES == 0) begin
          state_d = StIdle;
        end else begin
          state_d = StGap;
          busy_d  = 1'b1;
          gap_d   = GapLast;
        end
      end

      StGap: begin
        wr_drop_d = wr_en;
        if (gap_q == '0) begin
          state_d = StIdle;
        end else begin
          busy_d = 1'b1;
          gap_d  = gap_q - 1'b1;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase

    full_d = (count_d == MaxCnt);
  end

  // Control state and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StIdle;
      count_q   <= '0;
      idx_q     <= '0;
      gap_q     <= '0;
      crc_q     <= CRC_INIT;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      datain_q  <= 8'h00;
      busy_q    <= 1'b0;
      full_q    <= 1'b0;
      wr_drop_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      crc_q     <= crc_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      datain_q  <= datain_d;
      busy_q    <= busy_d;
      full_q    <= full_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  // Payload storage; contents are don't-care once count is cleared.
  always_ff @(posedge clock) begin
    buf_q <= buf_d;
  end

  assign start   = start_q;
  assign stop    = stop_q;
  assign datain  = datain_q;
  assign busy    = busy_q;
  assign count   = count_q;
  assign full    = full_q;
  assign wr_drop = wr_drop_q;

endmodule

// File: tb/tb_frame_crc_tx.sv
// Scoreboard bench for frame_crc_tx: stimulus pushes expected beats, a monitor
// pops and compares them whenever the DUT presents frame output.
module tb_frame_crc_tx;

  localparam int unsigned MaxLen    = 16;
  localparam int unsigned GapCycles = 5;
  localparam int unsigned CntW      = $clog2(MaxLen + 1);

  typedef struct packed {
    logic [7:0] data;
    logic       start;
    logic       stop;
  } beat_t;

  typedef logic [7:0] byte_q_t[$];

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            wr_en = 1'b0;
  logic [7:0]      wr_data = 8'h00;
  logic            send = 1'b0;
  logic            start;
  logic            stop;
  logic [7:0]      datain;
  logic            busy;
  logic [CntW-1:0] count;
  logic            full;
  logic            wr_drop;

  int      checks = 0;
  int      errors = 0;
  beat_t   exp_q[$];
  byte_q_t mbuf;
  logic    rst_seen = 1'b1;
  int      gap_left = 0;
  bit      in_frame = 1'b0;

  frame_crc_tx #(
    .MAX_LEN   (MaxLen),
    .GAP_CYCLES(GapCycles),
    .CRC_POLY  (8'h07),
    .CRC_INIT  (8'h00)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .wr_en  (wr_en),
    .wr_data(wr_data),
    .send   (send),
    .start  (start),
    .stop   (stop),
    .datain (datain),
    .busy   (busy),
    .count  (count),
    .full   (full),
    .wr_drop(wr_drop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // CRC as polynomial long division of the message bit stream (x^8+x^2+x+1).
  function automatic logic [7:0] ref_crc(input byte_q_t msg);
    logic [7:0] r;
    logic       fb;
    r = 8'h00;
    foreach (msg[i]) begin
      for (int b = 7; b >= 0; b--) begin
        fb = r[7] ^ msg[i][b];
        r  = {r[6:0], 1'b0};
        if (fb) r = r ^ 8'h07;
      end
    end
    return r;
  endfunction

  // Queue the expected beats of the buffered block and empty the model buffer.
  task automatic push_frame(output int n);
    beat_t e;
    n = mbuf.size();
    if (n > 0) begin
      foreach (mbuf[i]) begin
        e.data  = mbuf[i];
        e.start = (i == 0);
        e.stop  = 1'b0;
        exp_q.push_back(e);
      end
      e.data  = ref_crc(mbuf);
      e.start = 1'b0;
      e.stop  = 1'b1;
      exp_q.push_back(e);
    end
    mbuf.delete();
  endtask

  task automatic wait_done(input int cycles);
    repeat (cycles) @(posedge clock);
    #1;
    chk("frame_drained", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
    chk("idle_count", count, 0);
  endtask

  // Called 1 time unit after a rising edge.
  task automatic do_write(input logic [7:0] b);
    bit drop;
    drop    = (mbuf.size() >= MaxLen);
    wr_en   = 1'b1;
    wr_data = b;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    chk("wr_drop", wr_drop, drop);
    if (!drop) mbuf.push_back(b);
    chk("count", count, mbuf.size());
    chk("full", full, mbuf.size() == MaxLen);
  endtask

  task automatic do_send(input bit with_wr, input logic [7:0] b);
    bit drop;
    int n;
    drop    = with_wr && (mbuf.size() >= MaxLen);
    wr_en   = with_wr;
    wr_data = b;
    send    = 1'b1;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    send  = 1'b0;
    chk("send_wr_drop", wr_drop, drop);
    if (with_wr && !drop) mbuf.push_back(b);
    push_frame(n);
    chk("send_busy", busy, n > 0);
    wait_done(n + GapCycles + 2);
  endtask

  always @(posedge clock) rst_seen <= reset;

  // Monitor: compare every frame beat, idle cycle and gap cycle.
  always @(negedge clock) begin
    beat_t e;
    if (rst_seen) begin
      chk("reset_outputs", {start, stop, busy, full, wr_drop, count, datain}, '0);
      exp_q.delete();
      in_frame = 1'b0;
      gap_left = 0;
    end else if (start || stop || in_frame) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_beat", {start, stop, datain}, '0);
      end else begin
        e = exp_q.pop_front();
        chk("beat_data", datain, e.data);
        chk("beat_start_stop", {start, stop}, {e.start, e.stop});
        chk("beat_busy", busy, 1);
        if (e.stop) begin
          in_frame = 1'b0;
          gap_left = GapCycles;
        end else begin
          in_frame = 1'b1;
        end
      end
    end else begin
      chk("idle_data", {start, stop, datain}, '0);
      chk("gap_busy", busy, gap_left > 0);
      if (gap_left > 0) gap_left--;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int len;
    bit ws;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    chk("reset_count", count, 0);

    // "123456789" -> CRC 0xF4
    for (int i = 0; i < 9; i++) do_write(8'(8'h31 + i));
    do_send(1'b0, 8'h00);

    // Single 0xFF -> CRC 0xF3
    do_write(8'hFF);
    do_send(1'b0, 8'h00);

    // Fill to full, then one refused write
    for (int i = 0; i < MaxLen; i++) do_write(8'($urandom_range(0, 255)));
    do_write(8'hEE);
    do_send(1'b0, 8'h00);

    // send on an empty buffer is ignored; then write+send of 0x01 -> 01, 07
    do_send(1'b0, 8'h00);
    do_send(1'b1, 8'h01);

    // wr_en and send mid-frame are refused and do not start a second frame
    for (int i = 0; i < 8; i++) do_write(8'($urandom_range(0, 255)));
    send = 1'b1;
    @(posedge clock);
    #1;
    send = 1'b0;
    push_frame(n);
    @(posedge clock);
    #1;
    wr_en   = 1'b1;
    send    = 1'b1;
    wr_data = 8'hAA;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    send  = 1'b0;
    chk("busy_wr_drop", wr_drop, 1);
    wait_done(n + GapCycles + 2);

    // Reset while the third byte of an 8-byte frame is on datain
    for (int i = 0; i < 8; i++) do_write(8'($urandom_range(0, 255)));
    send = 1'b1;
    @(posedge clock);
    #1;
    send = 1'b0;
    push_frame(n);
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    chk("abort_outputs", {start, stop, busy, full, wr_drop, count, datain}, '0);
    @(posedge clock);
    #1;
    do_write(8'h00);
    do_send(1'b0, 8'h00);

    // Randomized frames
    for (int f = 0; f < 14; f++) begin
      len = $urandom_range(1, MaxLen);
      ws  = ($urandom_range(0, 2) == 0);
      for (int i = 0; i < len - (ws ? 1 : 0); i++) do_write(8'($urandom_range(0, 255)));
      if ((mbuf.size() == MaxLen) && ($urandom_range(0, 1) == 1)) begin
        do_write(8'($urandom_range(0, 255)));
      end
      do_send(ws, 8'($urandom_range(0, 255)));
    end

    chk("final_queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
